// File: rtl/divu_pkg.sv
// Shared definitions for the divider issue wrapper: default widths, watchdog limit
// and the sequencing FSM state encoding.
package divu_pkg;

   function automatic int tmo_for(input int n);
      return 2 * n + 8;
   endfunction

   localparam int N_DEF   = 256;
   localparam int TMO_DEF = tmo_for(N_DEF);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_CAPT = 2'd2,
      ST_OUT  = 2'd3
   } state_t;

endpackage

// File: rtl/divu_wdog.sv
// Watchdog counter for one divider run: cleared while idle, counts while enabled,
// and flags the cycle on which the count would reach TMO.
module divu_wdog #(
   parameter int TMO = 520
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         clr,
   input  logic                         en,
   output logic [$clog2(TMO+1)-1:0]     cnt,
   output logic                         hit
);

   localparam int CW = $clog2(TMO + 1);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (en && cnt != CW'(TMO)) begin
         cnt <= cnt + 1'b1;
      end
   end

   // Asserted while the counter is one short of TMO, so the parent leaves RUN
   // exactly TMO cycles after entering it.
   assign hit = en && (cnt == CW'(TMO - 1));

endmodule

// File: rtl/divu_issue.sv
// Request/response wrapper around an external iterative divider: latches operands,
// runs the divider under a watchdog, short-circuits divide-by-zero, holds results.
module divu_issue
   import divu_pkg::*;
#(
   parameter int N   = N_DEF,
   parameter int TMO = tmo_for(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [N-1:0]  in_divd,
   input  logic [N-1:0]  in_dvsr,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [N-1:0]  out_val,
   output logic [N-1:0]  out_rem,
   output logic          out_dbz,
   output logic          out_err,
   output logic          div_go,
   output logic [N-1:0]  div_divd,
   output logic [N-1:0]  div_dvsr,
   input  logic [N-1:0]  div_val,
   input  logic [N-1:0]  div_rem,
   input  logic          div_dbz,
   input  logic          div_rdy
);

   localparam int CW = $clog2(TMO + 1);

   state_t          state_q;
   state_t          state_d;
   logic [CW-1:0]   wd_cnt;
   logic            wd_hit;
   logic            accept;
   logic            dvsr_zero;
   logic            rdy_ok;
   logic            in_run;

   divu_wdog #(
      .TMO (TMO)
   ) u_wdog (
      .clk (clk),
      .rst (rst),
      .clr (!in_run),
      .en  (in_run),
      .cnt (wd_cnt),
      .hit (wd_hit)
   );

   assign in_run    = (state_q == ST_RUN);
   assign accept    = (state_q == ST_IDLE) && in_valid;
   assign dvsr_zero = (in_dvsr == '0);
   // The divider's ready flag may still be set from the previous operation
   // during the first RUN cycle, so it only counts once the watchdog has moved.
   assign rdy_ok    = in_run && div_rdy && (wd_cnt != '0);

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_OUT);
   assign div_go    = in_run;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (in_valid) state_d = dvsr_zero ? ST_OUT : ST_RUN;
         ST_RUN: begin
            if (rdy_ok) begin
               state_d = ST_CAPT;
            end else if (wd_hit) begin
               state_d = ST_OUT;
            end
         end
         ST_CAPT: state_d = ST_OUT;
         ST_OUT:  if (out_ready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Results are taken on the same edge that sees div_rdy; CAPT is then a
   // one-cycle gap that keeps div_go low while the divider re-initialises.
   always_ff @(posedge clk) begin
      if (rst) begin
         div_divd <= '0;
         div_dvsr <= '0;
         out_val  <= '0;
         out_rem  <= '0;
         out_dbz  <= 1'b0;
         out_err  <= 1'b0;
      end else if (accept) begin
         div_divd <= in_divd;
         div_dvsr <= in_dvsr;
         if (dvsr_zero) begin
            out_val <= '0;
            out_rem <= in_divd;
            out_dbz <= 1'b1;
            out_err <= 1'b0;
         end
      end else if (rdy_ok) begin
         out_val <= div_val;
         out_rem <= div_rem;
         out_dbz <= div_dbz;
         out_err <= 1'b0;
      end else if (in_run && wd_hit) begin
         out_val <= '0;
         out_rem <= '0;
         out_dbz <= 1'b0;
         out_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_divu_issue.sv
// Scoreboard bench for divu_issue with a behavioural multi-cycle divider model
// that can be told to stall forever.
module tb_divu_issue;

   localparam int N   = 16;
   localparam int TMO = 2 * N + 8;
   localparam int LAT = 6;

   typedef struct {
      logic [N-1:0] val;
      logic [N-1:0] rem;
      logic         dbz;
      logic         err;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [N-1:0]  in_divd = '0;
   logic [N-1:0]  in_dvsr = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [N-1:0]  out_val;
   logic [N-1:0]  out_rem;
   logic          out_dbz;
   logic          out_err;
   logic          div_go;
   logic [N-1:0]  div_divd;
   logic [N-1:0]  div_dvsr;
   logic [N-1:0]  rd_val = '0;
   logic [N-1:0]  rd_rem = '0;
   logic          rd_dbz = 1'b0;
   logic          rd_rdy = 1'b0;
   int            rd_cnt = 0;
   logic          stall  = 1'b0;

   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t exp_q[$];

   logic go_prev = 1'b0;
   int   go_rise = -1;
   int   go_fall = -1;
   int   low_run = 0;
   int   last_gap = -1;
   int   go_hi_total = 0;

   divu_issue #(
      .N   (N),
      .TMO (TMO)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_divd   (in_divd),
      .in_dvsr   (in_dvsr),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_val   (out_val),
      .out_rem   (out_rem),
      .out_dbz   (out_dbz),
      .out_err   (out_err),
      .div_go    (div_go),
      .div_divd  (div_divd),
      .div_dvsr  (div_dvsr),
      .div_val   (rd_val),
      .div_rem   (rd_rem),
      .div_dbz   (rd_dbz),
      .div_rdy   (rd_rdy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Divider model: rdy stays set after a result until the next run starts.
   always @(posedge clk) begin
      if (!div_go) begin
         rd_cnt <= 0;
      end else begin
         rd_cnt <= rd_cnt + 1;
         if (rd_cnt == 0) rd_rdy <= 1'b0;
         if (!stall && rd_cnt == LAT) begin
            rd_rdy <= 1'b1;
            rd_val <= div_divd / div_dvsr;
            rd_rem <= div_divd % div_dvsr;
            rd_dbz <= 1'b0;
         end
      end
   end

   always @(posedge clk) begin
      if (div_go && !go_prev) begin
         go_rise  <= cyc;
         last_gap <= low_run;
      end
      if (!div_go && go_prev) go_fall <= cyc;
      low_run <= div_go ? 0 : low_run + 1;
      go_prev <= div_go;
      if (div_go) go_hi_total <= go_hi_total + 1;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation time limit reached");
      $fatal(1, "time limit");
   end

   task automatic accept(input logic [N-1:0] a, input logic [N-1:0] b, output int t_acc);
      int   k;
      exp_t e;
      k = 0;
      in_valid = 1'b1;
      in_divd  = a;
      in_dvsr  = b;
      while (!in_ready && k < 200) begin
         @(negedge clk);
         k++;
      end
      n_tests++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL accept_wait: in_ready=%b required 1", in_ready);
      end
      t_acc = cyc;
      if (b == '0) begin
         e.val = '0; e.rem = a; e.dbz = 1'b1; e.err = 1'b0;
      end else if (stall) begin
         e.val = '0; e.rem = '0; e.dbz = 1'b0; e.err = 1'b1;
      end else begin
         e.val = a / b; e.rem = a % b; e.dbz = 1'b0; e.err = 1'b0;
      end
      exp_q.push_back(e);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_out(output int t, output bit ok);
      int k;
      k = 0;
      while (!out_valid && k < 200) begin
         @(negedge clk);
         k++;
      end
      ok = (out_valid === 1'b1);
      t  = cyc;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_tests++;
      if ({out_valid, div_go, out_dbz, out_err} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_ctrl: valid/go/dbz/err=%b required 0000", {out_valid, div_go, out_dbz, out_err});
      end
      n_tests++;
      if ({out_val, out_rem, div_divd, div_dvsr} !== '0) begin
         n_fail++;
         $display("FAIL reset_data: val=%h rem=%h divd=%h dvsr=%h required all 0", out_val, out_rem, div_divd, div_dvsr);
      end
      rst = 1'b0;
      @(negedge clk);
      n_tests++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_ready: in_ready=%b required 1", in_ready);
      end
   endtask

   task automatic test_full_scale();
      int   t_acc, t_out;
      bit   ok;
      exp_t e;
      out_ready = 1'b0;
      accept('1, '1, t_acc);
      wait_out(t_out, ok);
      n_tests++;
      if (!ok) begin
         n_fail++;
         $display("FAIL full_out_timeout: out_valid=%b required 1", out_valid);
      end else begin
         e = exp_q.pop_front();
         n_tests++;
         if ({out_val, out_rem, out_dbz, out_err} !== {e.val, e.rem, e.dbz, e.err}) begin
            n_fail++;
            $display("FAIL full_result: got %h r %h dbz %b err %b, required %h r %h dbz %b err %b",
                     out_val, out_rem, out_dbz, out_err, e.val, e.rem, e.dbz, e.err);
         end
      end
      n_tests++;
      if (go_rise !== t_acc + 1 || go_fall !== t_acc + LAT + 3) begin
         n_fail++;
         $display("FAIL full_go_window: go high %0d..%0d required %0d..%0d",
                  go_rise, go_fall - 1, t_acc + 1, t_acc + LAT + 2);
      end
      n_tests++;
      if (t_out !== t_acc + LAT + 4) begin
         n_fail++;
         $display("FAIL full_latency: out_valid at %0d required %0d", t_out, t_acc + LAT + 4);
      end
      out_ready = 1'b1;
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL full_release: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      fork
         begin
            int t;
            accept(16'd12, 16'd5, t);
            accept(16'd5, 16'd7, t);
         end
         begin
            int   t;
            bit   ok;
            exp_t e;
            for (int i = 0; i < 2; i++) begin
               wait_out(t, ok);
               n_tests++;
               if (!ok || exp_q.size() == 0) begin
                  n_fail++;
                  $display("FAIL b2b_out_%0d: out_valid=%b queued=%0d required 1 and >0", i, out_valid, exp_q.size());
               end else begin
                  e = exp_q.pop_front();
                  if ({out_val, out_rem, out_dbz, out_err} !== {e.val, e.rem, e.dbz, e.err}) begin
                     n_fail++;
                     $display("FAIL b2b_result_%0d: got %0d r %0d dbz %b err %b, required %0d r %0d dbz %b err %b",
                              i, out_val, out_rem, out_dbz, out_err, e.val, e.rem, e.dbz, e.err);
                  end
               end
               @(negedge clk);
            end
         end
      join
      n_tests++;
      if (last_gap < 2) begin
         n_fail++;
         $display("FAIL b2b_go_gap: div_go low %0d cycles between runs, required >= 2", last_gap);
      end
   endtask

   task automatic test_dbz();
      int   t_acc, t_out, go_before;
      bit   ok;
      exp_t e;
      out_ready = 1'b0;
      go_before = go_hi_total;
      accept(16'd100, 16'd0, t_acc);
      wait_out(t_out, ok);
      n_tests++;
      if (!ok || t_out !== t_acc + 1) begin
         n_fail++;
         $display("FAIL dbz_latency: out_valid=%b at %0d required 1 at %0d", out_valid, t_out, t_acc + 1);
      end
      if (ok) begin
         e = exp_q.pop_front();
         n_tests++;
         if ({out_val, out_rem, out_dbz, out_err} !== {e.val, e.rem, e.dbz, e.err}) begin
            n_fail++;
            $display("FAIL dbz_result: got %0d r %0d dbz %b err %b, required %0d r %0d dbz %b err %b",
                     out_val, out_rem, out_dbz, out_err, e.val, e.rem, e.dbz, e.err);
         end
      end
      out_ready = 1'b1;
      @(negedge clk);
      n_tests++;
      if (go_hi_total !== go_before || div_go !== 1'b0) begin
         n_fail++;
         $display("FAIL dbz_no_go: div_go high for %0d cycles, required 0", go_hi_total - go_before);
      end
   endtask

   task automatic test_stall_out();
      int   t_acc, t_out;
      bit   ok, bad;
      exp_t e;
      out_ready = 1'b0;
      accept(16'd45, 16'd9, t_acc);
      wait_out(t_out, ok);
      n_tests++;
      if (!ok) begin
         n_fail++;
         $display("FAIL hold_out_timeout: out_valid=%b required 1", out_valid);
      end else begin
         e = exp_q.pop_front();
         if ({out_val, out_rem, out_dbz, out_err} !== {e.val, e.rem, e.dbz, e.err}) begin
            n_fail++;
            $display("FAIL hold_result: got %0d r %0d dbz %b err %b, required %0d r %0d",
                     out_val, out_rem, out_dbz, out_err, e.val, e.rem);
         end
      end
      bad = 1'b0;
      in_valid = 1'b1;
      in_divd  = 16'd77;
      in_dvsr  = 16'd3;
      for (int i = 0; i < 10; i++) begin
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_val !== 16'd5 || out_rem !== 16'd0) bad = 1'b1;
         @(negedge clk);
      end
      n_tests++;
      if (bad) begin
         n_fail++;
         $display("FAIL hold_stable: valid=%b ready=%b val=%0d rem=%0d required 1 0 5 0", out_valid, in_ready, out_val, out_rem);
      end
      out_ready = 1'b1;
      in_valid  = 1'b0;
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b0 || div_divd !== 16'd45) begin
         n_fail++;
         $display("FAIL hold_release: out_valid=%b div_divd=%0d required 0 45", out_valid, div_divd);
      end
   endtask

   task automatic test_timeout();
      int   t_acc, t_out;
      bit   ok;
      exp_t e;
      out_ready = 1'b0;
      stall = 1'b1;
      accept(16'd7, 16'd3, t_acc);
      wait_out(t_out, ok);
      n_tests++;
      if (!ok || t_out - go_rise !== TMO) begin
         n_fail++;
         $display("FAIL tmo_latency: out_valid=%b after %0d RUN cycles, required 1 after %0d", out_valid, t_out - go_rise, TMO);
      end
      if (ok) begin
         e = exp_q.pop_front();
         n_tests++;
         if ({out_val, out_rem, out_dbz, out_err, div_go} !== {e.val, e.rem, e.dbz, e.err, 1'b0}) begin
            n_fail++;
            $display("FAIL tmo_result: got %0d r %0d dbz %b err %b go %b, required 0 r 0 dbz 0 err 1 go 0",
                     out_val, out_rem, out_dbz, out_err, div_go);
         end
      end
      stall = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      accept(16'd20, 16'd6, t_acc);
      wait_out(t_out, ok);
      n_tests++;
      if (!ok || exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL tmo_recover_timeout: out_valid=%b required 1", out_valid);
      end else begin
         e = exp_q.pop_front();
         if ({out_val, out_rem, out_dbz, out_err} !== {e.val, e.rem, e.dbz, e.err}) begin
            n_fail++;
            $display("FAIL tmo_recover: got %0d r %0d err %b, required %0d r %0d err %b",
                     out_val, out_rem, out_err, e.val, e.rem, e.err);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_run();
      int t_acc;
      bit seen;
      out_ready = 1'b1;
      accept(16'd9, 16'd2, t_acc);
      @(negedge clk);
      n_tests++;
      if (div_go !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_run_go: div_go=%b required 1", div_go);
      end
      rst = 1'b1;
      @(negedge clk);
      n_tests++;
      if (div_go !== 1'b0 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_run_abort: div_go=%b out_valid=%b required 0 0", div_go, out_valid);
      end
      rst = 1'b0;
      exp_q.delete();
      @(negedge clk);
      n_tests++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_run_ready: in_ready=%b required 1", in_ready);
      end
      seen = 1'b0;
      for (int i = 0; i < 3 * LAT + 10; i++) begin
         if (out_valid !== 1'b0 || div_go !== 1'b0) seen = 1'b1;
         @(negedge clk);
      end
      n_tests++;
      if (seen || out_val !== '0 || div_divd !== '0) begin
         n_fail++;
         $display("FAIL rst_run_quiet: stray activity=%b out_val=%0d div_divd=%0d required 0 0 0", seen, out_val, div_divd);
      end
   endtask

   initial begin
      test_reset();
      test_full_scale();
      test_back_to_back();
      test_dbz();
      test_stall_out();
      test_timeout();
      test_reset_mid_run();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/divu_issue.md
DIVU_ISSUE -- requirements
Module: divu_issue

Interface
REQ-001 SHALL have parameter N, default 256: operand/result width in bits.
REQ-002 SHALL have parameter TMO, default 2*N+8: watchdog limit in clk cycles for one divider run.
REQ-003 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  in  1  request valid.
REQ-006 SHALL have port in_ready  out  1  request accepted when in_valid & in_ready.
REQ-007 SHALL have ports in_divd, in_dvsr  in  N  dividend, divisor.
REQ-008 SHALL have port out_valid  out  1  result valid.
REQ-009 SHALL have port out_ready  in  1  result consumed when out_valid & out_ready.
REQ-010 SHALL have ports out_val, out_rem  out  N  quotient, remainder.
REQ-011 SHALL have ports out_dbz, out_err  out  1  divide-by-zero flag, watchdog timeout flag.
REQ-012 SHALL have port div_go  out  1  drives divider rst input; high = load operands and run, low = idle/re-init.
REQ-013 SHALL have ports div_divd, div_dvsr  out  N  operands to divider.
REQ-014 SHALL have ports div_val, div_rem  in  N; div_dbz  in  1; div_rdy  in  1  divider results, data_rdy.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, CAPT, OUT.
REQ-016 IDLE: in_ready=1; on accept, latch operands into div_divd/div_dvsr; next state RUN, or OUT directly if in_dvsr==0.
REQ-017 Divide-by-zero shortcut: no div_go pulse; out_val=0, out_rem=in_divd, out_dbz=1, out_err=0; out_valid rises cycle after accept.
REQ-018 RUN: div_go=1, operands held stable, watchdog counts from 0 on RUN entry.
REQ-019 RUN: div_rdy SHALL be ignored in the first RUN cycle (stale flag from previous op); from second cycle on, div_rdy=1 -> CAPT.
REQ-020 CAPT: register div_val, div_rem, div_dbz into outputs, out_err=0, div_go=0; next state OUT (single cycle).
REQ-021 Watchdog reaching TMO in RUN with no div_rdy: outputs val=0, rem=0, dbz=0, out_err=1, div_go=0, go to OUT; div_rdy same cycle as TMO wins (normal capture).
REQ-022 OUT: out_valid=1, outputs stable until handshake; in_ready=0; on out_ready -> IDLE, out_valid=0 next cycle.
REQ-023 Latency: accept at T -> div_go high T+1; div_rdy sampled high at R -> out_valid high R+2 (CAPT at R+1).
REQ-024 div_go SHALL be low at least 2 cycles (CAPT/OUT, IDLE) between consecutive runs.
REQ-025 in_ready SHALL be high only in IDLE; one request in flight maximum; requests while busy are not accepted.
REQ-026 div_rdy outside RUN SHALL be ignored.
REQ-027 Outputs SHALL be registered; no combinational path in_* -> out_*.

Reset
REQ-028 rst=1 at edge: state=IDLE, div_go=0, out_valid=0, out_val/out_rem/out_dbz/out_err=0, div_divd/div_dvsr=0, watchdog=0; in_ready=1 first cycle after rst falls.
REQ-029 rst mid-RUN or mid-OUT SHALL abort the operation; in-flight result is discarded, no out_valid produced.

Structure
REQ-030 Package divu_pkg SHALL hold N default, TMO default, and the FSM state enum.
REQ-031 Watchdog SHALL be sub-module divu_wdog (clear/enable, $clog2(TMO+1)-bit counter, hit output); divider stays outside, connected at the parent.

Verification
REQ-032 in_divd='1, in_dvsr='1 with reference divider -> out_val=1, out_rem=0, out_dbz=0, div_go high exactly from T+1 to div_rdy+1.
REQ-033 12/5 then 5/7 back-to-back, out_ready=1 -> 2 rem 2, then 0 rem 5; div_go low >=2 cycles between runs.
REQ-034 100/0 -> out_val=0, out_rem=100, out_dbz=1, out_valid at T+1, div_go never asserted.
REQ-035 45/9 with out_ready low 10 cycles -> out_valid held, out_val=5, out_rem=0 stable, in_ready=0 throughout.
REQ-036 Stub divider never asserting div_rdy -> out_err=1, out_val=out_rem=0 at RUN entry + TMO cycles; next request accepted normally.
REQ-037 rst pulsed 1 cycle mid-RUN -> div_go=0, out_valid never rises for that request, in_ready=1 cycle after rst falls.
